debounce4: RTL

Four-channel push-button conditioner for the IceZUM board. It synchronises four raw, bouncing button inputs to `clk`, debounces each one with a stable-time counter, and outputs clean levels plus one-cycle press pulses. It sits directly upstream of the 4-input OR gate block: `z0..z3` connect straight to that block's `x0..x3`, so the OR output reflects debounced buttons and never contact bounce.

---
 rtl/debounce4_pkg.sv | 10 +
 rtl/debounce1.sv | 47 ++++
 rtl/debounce4.sv | 41 ++++
 3 files changed

// File: rtl/debounce4_pkg.sv
// Shared button-conditioning constants for the IceZUM board.
// Other button-facing blocks derive their debounce defaults from here as well.
package debounce4_pkg;

    localparam int BOARD_CLK_HZ   = 12_000_000;
    localparam int DEBOUNCE_MS    = 10;
    localparam int DB_CYCLES_DEF  = (BOARD_CLK_HZ / 1000) * DEBOUNCE_MS;
    localparam int CNT_W_DEF      = $clog2(DB_CYCLES_DEF);

endpackage

// File: rtl/debounce1.sv
// One push-button channel: two-flop synchroniser, stable-time debounce counter,
// registered clean level and a one-cycle press pulse.
module debounce1
    import debounce4_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z,
    output logic p
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            z       <= 1'b0;
            p       <= 1'b0;
            cnt     <= '0;
        end else begin
            // synchroniser stages
            sync_p0 <= x;
            sync_p1 <= sync_p0;
            p       <= 1'b0;
            // any agreeing sample restarts qualification of the new level
            if (sync_p1 == z) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                z   <= sync_p1;
                p   <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/debounce4.sv
// Four independent debounced button channels feeding the 4-input OR block.
// Pure structural wrapper around debounce1.
module debounce4
    import debounce4_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic x3,
    output logic z0,
    output logic z1,
    output logic z2,
    output logic z3,
    output logic p0,
    output logic p1,
    output logic p2,
    output logic p3
);

    debounce1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch0 (
        .clk(clk), .rst(rst), .x(x0), .z(z0), .p(p0)
    );

    debounce1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch1 (
        .clk(clk), .rst(rst), .x(x1), .z(z1), .p(p1)
    );

    debounce1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch2 (
        .clk(clk), .rst(rst), .x(x2), .z(z2), .p(p2)
    );

    debounce1 #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_ch3 (
        .clk(clk), .rst(rst), .x(x3), .z(z3), .p(p3)
    );

endmodule
